// File: rtl/piso_serializer_pkg.sv
// Shared types and defaults for the parallel-in/serial-out transmitter.
// The state encoding is fixed so that SHIFT is the only state with a high bit.
package piso_serializer_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/piso_bit_counter.sv
// Loadable down-counter with a zero flag.
// Tracks how many bits of the current word remain after the one on the wire.
module piso_bit_counter #(
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          dec,
    input  logic [CW-1:0] load_val,
    output logic [CW-1:0] count,
    output logic          zero
);

    logic [CW-1:0] count_reg;

    // Load wins over decrement so a back-to-back reload at zero is never lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (dec) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign count = count_reg;
    assign zero  = (count_reg == '0);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter: accepts a word over valid/ready and
// sends it one bit per clock with frame start/done markers, back-to-back capable.
module piso_serializer
    import piso_serializer_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             sdo,
    output logic             sdo_bar,
    output logic             sdo_valid,
    output logic             frame_start,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    state_t           state_reg;
    logic [WIDTH-1:0] shreg_reg;
    logic [WIDTH-1:0] shreg_shifted;
    logic [CW-1:0]    cnt;
    logic             cnt_zero;
    logic             out_bit;
    logic             accept;
    logic             in_shift;

    assign in_shift   = (state_reg == ST_SHIFT);
    assign load_ready = (state_reg == ST_IDLE) | (in_shift & cnt_zero);
    assign accept     = load_valid & load_ready;

    piso_bit_counter #(
        .CW(CW)
    ) u_bit_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .dec      (in_shift & ~cnt_zero),
        .load_val (LAST_CNT),
        .count    (cnt),
        .zero     (cnt_zero)
    );

    // Output end of the shift register and the matching zero-fill direction.
    generate
        if (LSB_FIRST) begin : g_lsb_first
            assign out_bit       = shreg_reg[0];
            assign shreg_shifted = {1'b0, shreg_reg[WIDTH-1:1]};
        end else begin : g_msb_first
            assign out_bit       = shreg_reg[WIDTH-1];
            assign shreg_shifted = {shreg_reg[WIDTH-2:0], 1'b0};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            shreg_reg <= '0;
        end else if (accept) begin
            state_reg <= ST_SHIFT;
            shreg_reg <= load_data;
        end else if (in_shift) begin
            if (!cnt_zero) begin
                shreg_reg <= shreg_shifted;
            end else begin
                state_reg <= ST_IDLE;
                shreg_reg <= '0;
            end
        end
    end

    assign sdo_valid   = in_shift;
    assign sdo         = in_shift & out_bit;
    assign sdo_bar     = ~sdo;
    assign frame_start = in_shift & (cnt == LAST_CNT);
    assign done        = in_shift & cnt_zero;

endmodule
